stream_mux4_rr: RTL

- Four-input, one-output stream merger with valid/ready handshakes. It is the gather end that pairs with the team's 1:4 demux fan-out.
- Arbitrates four producer channels round-robin into a single registered output.
- Tags every output beat with the 2-bit source index `out_sel`, so a downstream 1:4 demux can steer it back to the matching channel.
- Sits between the channel-level producers and a shared single-lane consumer.

---
 rtl/stream_mux4_rr.sv | 124 ++++++++++++
 1 files changed

// File: rtl/stream_mux4_rr.sv
// rtl/stream_mux4_rr.sv - 4:1 round-robin stream merger with registered output beat and source tag
// Define STREAM_MUX4_PKT_LOCK_EN to add in_last/out_last and hold the grant for a whole packet.
module stream_mux4_rr #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      in_valid,
    input  logic [4*DW-1:0] in_data,
`ifdef STREAM_MUX4_PKT_LOCK_EN
    input  logic [3:0]      in_last,
    output logic            out_last,
`endif
    output logic [3:0]      in_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [1:0]      out_sel,
    input  logic            out_ready
);
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_rr_ptr, w_rr_ptr_nxt;
    logic [1:0]    r_lock_ch, w_lock_ch_nxt;
    logic          r_out_valid;
    logic [DW-1:0] r_out_data;
    logic [1:0]    r_out_sel;
    logic          w_load_en;
    logic          w_found;
    logic          w_xfer;
    logic          w_beat_last;
    logic [1:0]    w_grant;
    logic [3:0]    w_req;

    assign w_load_en = !r_out_valid || out_ready;
    // A locked packet masks every other requester until its last beat.
    assign w_req     = (r_state == LOCKED) ? (in_valid & (4'b0001 << r_lock_ch)) : in_valid;

    always_comb begin
        w_grant = 2'd0;
        w_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!w_found && w_req[r_rr_ptr + 2'(k)]) begin
                w_grant = r_rr_ptr + 2'(k);
                w_found = 1'b1;
            end
        end
    end

    assign w_xfer   = w_found && w_load_en;
    assign in_ready = (rst_n && w_xfer) ? (4'b0001 << w_grant) : 4'b0000;

`ifdef STREAM_MUX4_PKT_LOCK_EN
    assign w_beat_last = in_last[w_grant];
`else
    assign w_beat_last = 1'b1;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_lock_ch_nxt = r_lock_ch;
        if (w_xfer) begin
            case (r_state)
                IDLE: begin
                    w_rr_ptr_nxt = w_grant + 2'd1;
                    if (!w_beat_last) begin
                        w_state_nxt   = LOCKED;
                        w_lock_ch_nxt = w_grant;
                    end
                end
                LOCKED: begin
                    if (w_beat_last) begin
                        w_state_nxt  = IDLE;
                        w_rr_ptr_nxt = r_lock_ch + 2'd1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rr_ptr  <= 2'd0;
            r_lock_ch <= 2'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_lock_ch <= w_lock_ch_nxt;
        end
    end

    // Data and tag hold when the register empties without a new beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= 2'd0;
        end else if (w_load_en) begin
            r_out_valid <= w_xfer;
            if (w_xfer) begin
                r_out_data <= in_data[int'(w_grant)*DW +: DW];
                r_out_sel  <= w_grant;
            end
        end
    end

`ifdef STREAM_MUX4_PKT_LOCK_EN
    logic r_out_last;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_out_last <= 1'b0;
        else if (w_xfer)
            r_out_last <= w_beat_last;
    end
    assign out_last = r_out_last;
`endif

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
endmodule
